// File: rtl/trap_ctrl_pkg.sv
// rtl/trap_ctrl_pkg.sv - shared core trap types: exception causes, trap FSM states, trap kinds
package trap_ctrl_pkg;

    typedef enum logic [4:0] {
        EXC_INSTR_MISALIGNED = 5'd0,
        EXC_INSTR_FAULT      = 5'd1,
        EXC_ILLEGAL_INSTR    = 5'd2,
        EXC_BREAKPOINT       = 5'd3,
        EXC_LOAD_MISALIGNED  = 5'd4,
        EXC_LOAD_FAULT       = 5'd5,
        EXC_STORE_MISALIGNED = 5'd6,
        EXC_STORE_FAULT      = 5'd7,
        EXC_ECALL_U          = 5'd8,
        EXC_ECALL_S          = 5'd9,
        EXC_ECALL_M          = 5'd11
    } trap_causes;

    typedef enum logic [1:0] {
        IDLE     = 2'd0,
        FLUSH    = 2'd1,
        COMMIT   = 2'd2,
        REDIRECT = 2'd3
    } trap_state_t;

    typedef enum logic {
        TRAP = 1'b0,
        MRET = 1'b1
    } trap_kind_t;

endpackage

// File: rtl/trap_prio_sel.sv
// rtl/trap_prio_sel.sv - age-priority pick among exec exception, exec mret and ifetch exception
module trap_prio_sel #(
    parameter int XLEN = 32
) (
    input  logic            if_exc_valid,
    input  logic [4:0]      if_exc_cause,
    input  logic [XLEN-1:0] if_exc_pc,
    input  logic [XLEN-1:0] if_exc_tval,
    input  logic            ex_exc_valid,
    input  logic [4:0]      ex_exc_cause,
    input  logic [XLEN-1:0] ex_exc_pc,
    input  logic [XLEN-1:0] ex_exc_tval,
    input  logic            ex_mret,
    output logic            sel_valid,
    output logic            sel_is_mret,
    output logic            sel_ex,
    output logic            sel_if,
    output logic [4:0]      sel_cause,
    output logic [XLEN-1:0] sel_pc,
    output logic [XLEN-1:0] sel_tval
);

    // Exec holds the older instruction, and its exception outranks its own mret.
    always_comb begin
        sel_is_mret = 1'b0;
        sel_ex      = 1'b0;
        sel_if      = 1'b0;
        sel_cause   = '0;
        sel_pc      = '0;
        sel_tval    = '0;
        if (ex_exc_valid) begin
            sel_ex    = 1'b1;
            sel_cause = ex_exc_cause;
            sel_pc    = ex_exc_pc;
            sel_tval  = ex_exc_tval;
        end else if (ex_mret) begin
            sel_ex      = 1'b1;
            sel_is_mret = 1'b1;
        end else if (if_exc_valid) begin
            sel_if    = 1'b1;
            sel_cause = if_exc_cause;
            sel_pc    = if_exc_pc;
            sel_tval  = if_exc_tval;
        end
    end

    assign sel_valid = sel_ex | sel_if;

endmodule

// File: rtl/trap_ctrl.sv
// rtl/trap_ctrl.sv - trap sequencer: flush, commit mepc/mcause/mtval, redirect fetch
module trap_ctrl
    import trap_ctrl_pkg::*;
#(
    parameter int XLEN = 32
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            if_exc_valid,
    input  logic [4:0]      if_exc_cause,
    input  logic [XLEN-1:0] if_exc_pc,
    input  logic [XLEN-1:0] if_exc_tval,
    input  logic            ex_exc_valid,
    input  logic [4:0]      ex_exc_cause,
    input  logic [XLEN-1:0] ex_exc_pc,
    input  logic [XLEN-1:0] ex_exc_tval,
    input  logic            ex_mret,
    output logic            if_ack,
    output logic            ex_ack,
    output logic            flush,
    input  logic [XLEN-1:0] csr_mtvec,
    input  logic [XLEN-1:0] csr_mepc,
    output logic            csr_trap_we,
    output logic [XLEN-1:0] csr_mepc_wdata,
    output logic [XLEN-1:0] csr_mcause_wdata,
    output logic [XLEN-1:0] csr_mtval_wdata,
    output logic            redirect_valid,
    output logic [XLEN-1:0] redirect_pc,
    input  logic            redirect_ready,
    output logic            busy
);

    trap_state_t     state, state_nxt;
    trap_kind_t      kind_q;
    logic [4:0]      cause_q;
    logic [XLEN-1:0] pc_q, tval_q;

    logic            sel_valid, sel_is_mret, sel_ex, sel_if;
    logic [4:0]      sel_cause;
    logic [XLEN-1:0] sel_pc, sel_tval;

    trap_prio_sel #(.XLEN(XLEN)) u_prio (
        .if_exc_valid (if_exc_valid),
        .if_exc_cause (if_exc_cause),
        .if_exc_pc    (if_exc_pc),
        .if_exc_tval  (if_exc_tval),
        .ex_exc_valid (ex_exc_valid),
        .ex_exc_cause (ex_exc_cause),
        .ex_exc_pc    (ex_exc_pc),
        .ex_exc_tval  (ex_exc_tval),
        .ex_mret      (ex_mret),
        .sel_valid    (sel_valid),
        .sel_is_mret  (sel_is_mret),
        .sel_ex       (sel_ex),
        .sel_if       (sel_if),
        .sel_cause    (sel_cause),
        .sel_pc       (sel_pc),
        .sel_tval     (sel_tval)
    );

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) state <= IDLE;
        else      state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:     if (sel_valid) state_nxt = FLUSH;
            FLUSH:    state_nxt = (kind_q == MRET) ? REDIRECT : COMMIT;
            COMMIT:   state_nxt = REDIRECT;
            REDIRECT: if (redirect_ready) state_nxt = IDLE;
            default:  state_nxt = IDLE;
        endcase
    end

    // mret keeps the previous trap's cause/pc/tval; only the kind is taken.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            kind_q      <= TRAP;
            cause_q     <= '0;
            pc_q        <= '0;
            tval_q      <= '0;
            redirect_pc <= '0;
        end else begin
            if (state == IDLE && sel_valid) begin
                kind_q <= sel_is_mret ? MRET : TRAP;
                if (!sel_is_mret) begin
                    cause_q <= sel_cause;
                    pc_q    <= sel_pc;
                    tval_q  <= sel_tval;
                end
            end
            if (state == FLUSH && kind_q == MRET)
                redirect_pc <= csr_mepc;
            if (state == COMMIT)
                redirect_pc <= {csr_mtvec[XLEN-1:2], 2'b00};
        end
    end

    // Acks are gated by rst so a request held across reset is not acknowledged.
    always_comb begin
        if_ack         = 1'b0;
        ex_ack         = 1'b0;
        flush          = 1'b0;
        csr_trap_we    = 1'b0;
        redirect_valid = 1'b0;
        busy           = 1'b1;
        case (state)
            IDLE: begin
                busy   = 1'b0;
                if_ack = sel_if & rst;
                ex_ack = sel_ex & rst;
            end
            FLUSH:    flush          = 1'b1;
            COMMIT:   csr_trap_we    = 1'b1;
            REDIRECT: redirect_valid = 1'b1;
            default:  busy           = 1'b1;
        endcase
    end

    assign csr_mepc_wdata   = pc_q;
    assign csr_mcause_wdata = {{(XLEN-5){1'b0}}, cause_q};
    assign csr_mtval_wdata  = tval_q;

endmodule

// File: tb/tb_trap_ctrl.sv
// tb/tb_trap_ctrl.sv - self-checking bench for trap_ctrl
module tb_trap_ctrl;
    import trap_ctrl_pkg::*;

    logic        clk = 1'b0;
    logic        rst;
    logic        if_exc_valid, ex_exc_valid, ex_mret, redirect_ready;
    logic [4:0]  if_exc_cause, ex_exc_cause;
    logic [31:0] if_exc_pc, if_exc_tval, ex_exc_pc, ex_exc_tval, csr_mtvec, csr_mepc;
    logic        if_ack, ex_ack, flush, csr_trap_we, redirect_valid, busy;
    logic [31:0] csr_mepc_wdata, csr_mcause_wdata, csr_mtval_wdata, redirect_pc;

    int n_vec = 0;
    int n_err = 0;
    int cur   = 0;

    trap_ctrl #(.XLEN(32)) dut (
        .clk(clk), .rst(rst),
        .if_exc_valid(if_exc_valid), .if_exc_cause(if_exc_cause),
        .if_exc_pc(if_exc_pc), .if_exc_tval(if_exc_tval),
        .ex_exc_valid(ex_exc_valid), .ex_exc_cause(ex_exc_cause),
        .ex_exc_pc(ex_exc_pc), .ex_exc_tval(ex_exc_tval),
        .ex_mret(ex_mret), .if_ack(if_ack), .ex_ack(ex_ack), .flush(flush),
        .csr_mtvec(csr_mtvec), .csr_mepc(csr_mepc), .csr_trap_we(csr_trap_we),
        .csr_mepc_wdata(csr_mepc_wdata), .csr_mcause_wdata(csr_mcause_wdata),
        .csr_mtval_wdata(csr_mtval_wdata), .redirect_valid(redirect_valid),
        .redirect_pc(redirect_pc), .redirect_ready(redirect_ready), .busy(busy)
    );

    always #5 clk = ~clk;

    typedef struct {
        bit          exv, exm, ifv;
        logic [4:0]  exc, ifc;
        logic [31:0] expc, extv, ifpc, iftv, mtvec, mepc;
        int          stall;
        bit          e_exack, e_ifack, e_trap;
        logic [31:0] e_mepc, e_mcause, e_mtval, e_rpc;
    } vec_t;

    vec_t tbl[$];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL vec%0d %s: got %h expected %h", cur, name, act, exp);
        end
    endtask

    function automatic vec_t mkin(bit exv, bit exm, bit ifv, logic [4:0] exc, logic [31:0] expc,
                                  logic [31:0] extv, logic [4:0] ifc, logic [31:0] ifpc,
                                  logic [31:0] iftv, logic [31:0] mtvec, logic [31:0] mepc, int stall);
        vec_t v;
        v.exv = exv; v.exm = exm; v.ifv = ifv;
        v.exc = exc; v.expc = expc; v.extv = extv;
        v.ifc = ifc; v.ifpc = ifpc; v.iftv = iftv;
        v.mtvec = mtvec; v.mepc = mepc; v.stall = stall;
        v.e_exack = 0; v.e_ifack = 0; v.e_trap = 0;
        v.e_mepc = 0; v.e_mcause = 0; v.e_mtval = 0; v.e_rpc = 0;
        return v;
    endfunction

    function automatic vec_t mkexp(vec_t v, bit exack, bit ifack, bit trap, logic [31:0] mepc,
                                   logic [31:0] mcause, logic [31:0] mtval, logic [31:0] rpc);
        vec_t r = v;
        r.e_exack = exack; r.e_ifack = ifack; r.e_trap = trap;
        r.e_mepc = mepc; r.e_mcause = mcause; r.e_mtval = mtval; r.e_rpc = rpc;
        return r;
    endfunction

    // Reference: older stage wins, exec exception beats mret, handler base is mtvec rounded down to 4.
    function automatic vec_t model(vec_t v);
        vec_t r = v;
        r.e_exack = v.exv || v.exm;
        r.e_ifack = !r.e_exack && v.ifv;
        r.e_trap  = v.exv || (!v.exm && v.ifv);
        if (v.exv) begin
            r.e_mepc = v.expc; r.e_mcause = 32'(v.exc); r.e_mtval = v.extv;
        end else begin
            r.e_mepc = v.ifpc; r.e_mcause = 32'(v.ifc); r.e_mtval = v.iftv;
        end
        r.e_rpc = r.e_trap ? (v.mtvec - (v.mtvec % 4)) : v.mepc;
        return r;
    endfunction

    task automatic do_txn(input vec_t v);
        @(posedge clk); #1;
        ex_exc_valid = v.exv; ex_mret = v.exm; if_exc_valid = v.ifv;
        ex_exc_cause = v.exc; ex_exc_pc = v.expc; ex_exc_tval = v.extv;
        if_exc_cause = v.ifc; if_exc_pc = v.ifpc; if_exc_tval = v.iftv;
        csr_mtvec = v.mtvec; csr_mepc = v.mepc; redirect_ready = 0;
        @(negedge clk);
        chk("ex_ack@N", ex_ack, v.e_exack);
        chk("if_ack@N", if_ack, v.e_ifack);
        chk("busy@N", busy, 0);
        @(posedge clk); #1;
        ex_exc_valid = 0; ex_mret = 0;
        if (v.e_ifack) if_exc_valid = 0;
        @(negedge clk);
        chk("flush@N+1", flush, 1);
        chk("if_ack@N+1", if_ack, 0);
        chk("ex_ack@N+1", ex_ack, 0);
        chk("we@N+1", csr_trap_we, 0);
        @(posedge clk); #1;
        if_exc_valid = 0;
        if (v.e_trap) begin
            @(negedge clk);
            chk("we@N+2", csr_trap_we, 1);
            chk("mepc", csr_mepc_wdata, v.e_mepc);
            chk("mcause", csr_mcause_wdata, v.e_mcause);
            chk("mtval", csr_mtval_wdata, v.e_mtval);
            chk("rv@N+2", redirect_valid, 0);
            @(posedge clk); #1;
        end
        for (int s = 0; s < v.stall; s++) begin
            if_exc_valid = 1; csr_mtvec = ~v.mtvec; csr_mepc = ~v.mepc;
            @(negedge clk);
            chk("stall_rv", redirect_valid, 1);
            chk("stall_rpc", redirect_pc, v.e_rpc);
            chk("stall_busy", busy, 1);
            chk("stall_if_ack", if_ack, 0);
            @(posedge clk); #1;
        end
        if_exc_valid = 0; redirect_ready = 1;
        @(negedge clk);
        chk("rv", redirect_valid, 1);
        chk("rpc", redirect_pc, v.e_rpc);
        chk("we@redir", csr_trap_we, 0);
        @(posedge clk); #1;
        redirect_ready = 0;
        @(negedge clk);
        chk("busy@end", busy, 0);
        chk("rv@end", redirect_valid, 0);
        chk("if_ack@end", if_ack, 0);
    endtask

    initial begin
        vec_t v;
        rst = 0; redirect_ready = 0;
        if_exc_valid = 0; ex_exc_valid = 1; ex_mret = 0;
        if_exc_cause = 0; ex_exc_cause = 5'd2; if_exc_pc = 0; if_exc_tval = 0;
        ex_exc_pc = 32'h10; ex_exc_tval = 0; csr_mtvec = 0; csr_mepc = 0;
        #2;
        chk("rst_ex_ack", ex_ack, 0);
        chk("rst_busy", busy, 0);
        chk("rst_flush", flush, 0);
        chk("rst_we", csr_trap_we, 0);
        chk("rst_rv", redirect_valid, 0);
        chk("rst_rpc", redirect_pc, 0);
        chk("rst_mcause", csr_mcause_wdata, 0);
        @(posedge clk); #1;
        ex_exc_valid = 0;
        @(posedge clk); #1;
        rst = 1;

        v = mkin(1, 0, 0, EXC_ILLEGAL_INSTR, 32'h14, 32'hF11FD073, 0, 0, 0, 32'h1F, 0, 0);
        tbl.push_back(mkexp(v, 1, 0, 1, 32'h14, 2, 32'hF11FD073, 32'h1C));
        v = mkin(0, 0, 1, 0, 0, 0, EXC_ILLEGAL_INSTR, 32'h100, 32'h0000FFFF, 32'h0E, 0, 0);
        tbl.push_back(mkexp(v, 0, 1, 1, 32'h100, 2, 32'h0000FFFF, 32'hC));
        v = mkin(1, 0, 1, EXC_LOAD_FAULT, 32'h200, 32'hDEAD0000, EXC_INSTR_FAULT, 32'h300, 32'h300, 32'h80000001, 0, 0);
        tbl.push_back(mkexp(v, 1, 0, 1, 32'h200, 5, 32'hDEAD0000, 32'h80000000));
        v = mkin(0, 1, 0, 0, 0, 0, 0, 0, 0, 32'h1000, 32'h40, 0);
        tbl.push_back(mkexp(v, 1, 0, 0, 0, 0, 0, 32'h40));
        v = mkin(1, 1, 0, EXC_ECALL_M, 32'h50, 0, 0, 0, 0, 32'h1000, 32'h77, 0);
        tbl.push_back(mkexp(v, 1, 0, 1, 32'h50, 11, 0, 32'h1000));
        v = mkin(1, 0, 0, EXC_LOAD_MISALIGNED, 32'h64, 32'h67, 0, 0, 0, 32'h203, 0, 5);
        tbl.push_back(mkexp(v, 1, 0, 1, 32'h64, 4, 32'h67, 32'h200));
        v = mkin(0, 1, 1, 0, 0, 0, EXC_BREAKPOINT, 32'h8, 32'h8, 32'h400, 32'h1234, 2);
        tbl.push_back(mkexp(v, 1, 0, 0, 0, 0, 0, 32'h1234));

        for (int i = 0; i < 40; i++) begin
            int pick = $urandom_range(1, 7);
            v = mkin(pick[0], pick[1], pick[2], 5'($urandom_range(0, 15)), $urandom, $urandom,
                     5'($urandom_range(0, 15)), $urandom, $urandom, $urandom, $urandom,
                     $urandom_range(0, 3));
            tbl.push_back(model(v));
        end

        for (int i = 0; i < tbl.size(); i++) begin
            cur = i;
            do_txn(tbl[i]);
        end

        cur = -1;
        @(posedge clk); #1;
        ex_exc_valid = 1; ex_exc_cause = EXC_STORE_FAULT; ex_exc_pc = 32'h88; ex_exc_tval = 32'h99;
        csr_mtvec = 32'h500;
        @(posedge clk); #1;
        ex_exc_valid = 0;
        @(posedge clk); #1;
        @(negedge clk);
        chk("commit_we", csr_trap_we, 1);
        #1 rst = 0;
        #1;
        chk("rstmid_we", csr_trap_we, 0);
        chk("rstmid_busy", busy, 0);
        chk("rstmid_flush", flush, 0);
        chk("rstmid_rv", redirect_valid, 0);
        chk("rstmid_rpc", redirect_pc, 0);
        chk("rstmid_mepc", csr_mepc_wdata, 0);
        @(posedge clk); #1;
        rst = 1;
        for (int k = 0; k < 4; k++) begin
            @(negedge clk);
            chk("post_rst_we", csr_trap_we, 0);
            chk("post_rst_busy", busy, 0);
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule

// File: doc/trap_ctrl.md
# trap_ctrl

Trap sequencer for the core: accepts synchronous exception reports from the ifetch and exec stages and `mret` requests from exec, selects one by age priority, flushes the pipeline, commits `mepc`/`mcause`/`mtval` to the CSR file and redirects fetch to the `mtvec` target (or to `mepc` on `mret`). It sits between the pipeline stages, the CSR file and the fetch PC mux inside the core.

## Interface
- `XLEN`, default 32, data/address width (matches the core's `XLEN` define)
- `clk  in  1  core clock`
- `rst  in  1  asynchronous reset, active-low`
- `if_exc_valid  in  1  ifetch reports an exception; held until acked`
- `if_exc_cause  in  5  exception code (trap_causes)`
- `if_exc_pc  in  XLEN  faulting instruction address`
- `if_exc_tval  in  XLEN  trap value (faulting instruction bits or address)`
- `ex_exc_valid`, `ex_exc_cause`, `ex_exc_pc`, `ex_exc_tval`: same as above, exec stage
- `ex_mret  in  1  exec retires `mret`; held until acked`
- `if_ack  out  1  one-cycle pulse: ifetch request consumed`
- `ex_ack  out  1  one-cycle pulse: exec exception or mret consumed`
- `flush  out  1  one-cycle pulse: kill all in-flight instructions`
- `csr_mtvec  in  XLEN  current mtvec value`
- `csr_mepc  in  XLEN  current mepc value`
- `csr_trap_we  out  1  one-cycle pulse: write mepc/mcause/mtval`
- `csr_mepc_wdata`, `csr_mcause_wdata`, `csr_mtval_wdata`  out  XLEN  values written with `csr_trap_we`
- `redirect_valid  out  1  new fetch target valid; held until ready`
- `redirect_pc  out  XLEN  new fetch target`
- `redirect_ready  in  1  fetch accepted redirect`
- `busy  out  1  state != IDLE`

## Operation
- FSM states: IDLE, FLUSH, COMMIT, REDIRECT.
- IDLE: selection priority ex_exc > ex_mret > if_exc (exec is older). On any selected request: latch cause/pc/tval and kind (TRAP or MRET), pulse the matching ack, go FLUSH. No request: stay.
- FLUSH: `flush`=1 for one cycle. TRAP -> COMMIT; MRET -> REDIRECT with `redirect_pc` = `csr_mepc` sampled this cycle.
- COMMIT: `csr_trap_we`=1 for one cycle with mepc=latched pc, mcause={0, cause} zero-extended (bit XLEN-1 = 0, synchronous only), mtval=latched tval. `redirect_pc` = {csr_mtvec[XLEN-1:2], 2'b00} for every mtvec mode (vectoring applies only to interrupts, not handled here). -> REDIRECT.
- REDIRECT: `redirect_valid`=1, `redirect_pc` stable until `redirect_ready`; on ready -> IDLE.
- Requests arriving while busy are not acked; requesters hold them. Stale ifetch requests are killed by `flush` (ifetch deasserts), so no ifetch request survives an exec trap.
- An exception raised inside a handler before redirect completes is impossible (pipeline flushed); no nesting logic.

## Timing
- Reset (asserted low, async): state IDLE; all outputs 0, `redirect_pc`/CSR wdata 0.
- Request visible in IDLE at cycle N: ack at N (combinational from state+valid, registered latch at N edge), `flush` at N+1, `csr_trap_we` at N+2, `redirect_valid` from N+3. MRET: `redirect_valid` from N+2.
- With `redirect_ready` tied high: trap 4 cycles IDLE-to-IDLE, mret 3; next request acked earliest at N+4 / N+3.
- Simultaneous ex_exc and ex_mret: exception wins, only one `ex_ack`.
- Reset mid-sequence: abort, no partial CSR write after reset release.

## Structure
- Add `trap_state_t` (IDLE, FLUSH, COMMIT, REDIRECT) and `trap_kind_t` (TRAP, MRET) to the shared core package beside `trap_causes`.
- One sub-module: `trap_prio_sel`, combinational selection of the winning request and ack one-hot.

## Test plan
- Exec illegal: ex_exc cause=EXC_ILLEGAL_INSTR, pc=0x14, tval=0xF11FD073, mtvec=0x1F -> mepc=0x14, mcause=2, mtval=0xF11FD073, redirect_pc=0x1C at N+3.
- Ifetch illegal with mtvec=0x0E -> redirect_pc=0xC, mcause=2, ack on `if_ack` only.
- ex_exc and if_exc same cycle -> exec served, `if_ack` stays 0 until IDLE; after flush if_exc dropped -> no second trap.
- mret with csr_mepc=0x40 -> no `csr_trap_we`, redirect_pc=0x40 at N+2.
- redirect_ready held low 5 cycles -> `redirect_valid`, `redirect_pc` stable, `busy`=1 throughout, new requests not acked.
- rst low during COMMIT -> all outputs 0 immediately, IDLE after release, no CSR write.
